uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver for the debug and fiber serial links. It generalises the fixed 8N1, 53-cycle-half-period monitor to any bit period, data width, parity mode and stop-bit count. It adds majority-vote sampling, error flags and a first-word-fall-through (FWFT) output FIFO. It sits between a pin (FIBER_RX/DEBUG_RX) and the command decoder inside controller_top, in the ADC_DCO-derived clk domain.

Parameters:
CLKS_PER_BIT, 106, clk cycles per serial bit; must be >= 8.
DATA_BITS, 8, data bits per frame, 5..9, sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits, 1 or 2.
FIFO_DEPTH, 4, output FIFO entries; must be a power of 2, >= 2.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  raw serial input, idle high, asynchronous to clk
rx_data  out  DATA_BITS  FIFO head data, valid while rx_valid = 1
rx_perr  out  1  parity-error tag of the FIFO head entry
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pop; a pop occurs when rx_valid && rx_ready on a rising clk edge
frame_err  out  1  one-cycle pulse: a stop bit was sampled low
overrun  out  1  one-cycle pulse: a good frame was dropped because the FIFO was full
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: rx_valid = 0, rx_data = 0, rx_perr = 0, frame_err = 0, overrun = 0, busy = 0. The synchroniser flops reset to 1. The FIFO is empty and the FSM is in IDLE.
- Input synchroniser: rx passes through 2 flops, giving rxs. All decisions use rxs, so there is 2 cycles of input latency.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1 and has width $clog2(CLKS_PER_BIT). Bit centre is C = CLKS_PER_BIT/2 (integer division).
- Majority sampling: the bit value is the 2-of-3 vote of rxs at cnt = C-1, C and C+1. The value is latched at cnt = C+1.
- FSM states:
  - IDLE: a falling edge on rxs (previous 1, current 0) clears cnt and moves to START.
  - START: if the vote at the centre is 1, this is a false start; return to IDLE with no flags. Otherwise, at cnt wrap move to DATA with bit index 0.
  - DATA: the voted bit shifts in MSB-side (LSB first on the wire). After bit DATA_BITS-1, move to PARITY if PARITY != 0, else to STOP.
  - PARITY: compute the expected bit as XOR of the data bits, inverted for odd parity. perr = (voted != expected).
  - STOP: at the vote of each stop bit:
    - If the voted bit is 0: pulse frame_err, discard the frame, go to BREAK.
    - If this is the last stop bit and it is 1: push {perr, data} on the same cycle as the vote, or pulse overrun if the FIFO is full. Go to IDLE immediately; there is no wait for the end of the stop bit, so back-to-back frames are accepted.
  - BREAK: wait for rxs = 1, then go to IDLE. A held-low line yields exactly one frame_err.
- Latency: rx_valid rises 1 cycle after the push cycle (FWFT register).
- Pop and push in the same cycle:
  - With the FIFO full, both happen and no overrun occurs.
  - With the FIFO empty, rx_valid stays 0 for that cycle and the pushed entry appears on the next cycle.
- Frames with a parity error are stored, with rx_perr = 1. Framing-error frames are never stored.
- FIFO pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full when the MSBs differ and the rest are equal; empty when the pointers are equal.
- Reset mid-frame: the FSM returns to IDLE and the FIFO is flushed. No pulses are issued on release. If rx is low at the release of reset, that is not treated as a start bit: the falling-edge detector requires a prior 1.
- frame_err and overrun are never high for 2 consecutive cycles from one event.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
  - PARITY mode constants: PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
- One natural sub-module, sync_fifo_fwft, parametrised by WIDTH = DATA_BITS+1 and DEPTH = FIFO_DEPTH. It is reusable by the matching TX block.
- The FSM, bit counter and vote logic stay in uart_rx_fifo.

Test Plan:
- Default parameters, rx_ready = 1, send 8N1 0x55, then 0xA3 back-to-back -> rx_data = 0x55 then 0xA3, rx_perr = 0 for both, with rx_valid rising 1 cycle after each stop-bit vote.
- Send 0x3C with the stop bit driven low for 2 bit times -> a single frame_err pulse, no push, busy held until rx returns high, then the next byte 0x01 is received correctly.
- Drive a 20-cycle low glitch on an idle line -> no rx_valid, no flags, and busy falls within CLKS_PER_BIT/2 + 4 cycles.
- rx_ready = 0, FIFO_DEPTH = 4, send 0x10..0x14 -> 4 entries held, one overrun pulse on the 5th, then pops return 0x10, 0x11, 0x12, 0x13 in order.
- PARITY = 2, DATA_BITS = 7: send 0x41 with a correct parity bit and then a flipped one -> rx_perr = 0, then 1, with rx_data = 0x41 both times; also send a single-cycle 1 spike mid-bit in each data bit -> the data is unchanged.
- Assert rst_n low for 3 cycles during data bit 4, with 2 entries queued -> all outputs return to reset values, the FIFO is empty, and the next full frame 0x7E decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   uart_state_e : receiver FSM state encoding
//   PAR_*        : parity mode constants for the PARITY parameter
//   vote3        : 2-of-3 majority helper used for bit sampling
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic logic vote3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head entry is presented on rdata
// whenever valid is high; a pop consumes it on the next rising clk edge.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   push       : write wdata this cycle (accepted when not full, or when full and popping)
//   wdata      : data to write
//   full       : no free entry
//   rdata      : head entry
//   valid      : FIFO not empty
//   pop        : consume the head entry (ignored while empty)
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    input  logic             pop
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign valid   = (wptr_q != rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop & valid;
    // When full, a simultaneous pop frees the slot being written.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= wdata;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with majority-vote sampling, parity/framing checks and a
// FWFT output FIFO holding {parity error, data}.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : raw serial input, idle high, asynchronous to clk
//   rx_data    : FIFO head data
//   rx_perr    : parity-error tag of the FIFO head
//   rx_valid   : FIFO not empty
//   rx_ready   : consumer pop (effective when rx_valid is high)
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, good frame dropped because the FIFO was full
//   busy       : FSM not idle
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 106,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_CM1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_C   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_CP1 = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [IW-1:0] BIT_LAST = IW'(DATA_BITS - 1);

    uart_state_e          state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        bit_idx_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 perr_q;
    logic                 frame_err_q, overrun_q;

    logic       rx_meta_q, rxs_q, rxs_prev_q;
    logic [1:0] sync_ok_q;
    logic [1:0] samp_q;

    logic at_vote, at_wrap, vote, fall, last_stop, par_exp;
    logic push_req, fifo_full, pop;
    logic [DATA_BITS:0] fifo_rdata;

    // Two-flop synchroniser. sync_ok_q marks when rxs_q holds a real sample, so the
    // reset value of the synchroniser can never act as the "prior 1" of a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b0;
            sync_ok_q  <= 2'b00;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            sync_ok_q  <= {sync_ok_q[0], 1'b1};
            rxs_prev_q <= sync_ok_q[1] & rxs_q;
        end
    end

    assign fall      = rxs_prev_q & ~rxs_q;
    assign at_vote   = (cnt_q == CNT_CP1);
    assign at_wrap   = (cnt_q == CNT_MAX);
    assign vote      = vote3(samp_q[0], samp_q[1], rxs_q);
    assign last_stop = (STOP_BITS == 1) || (stop_idx_q == 1'b1);
    assign par_exp   = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
    assign pop       = rx_valid & rx_ready;
    assign push_req  = (state_q == StStop) && at_vote && vote && last_stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shreg_q     <= '0;
            perr_q      <= 1'b0;
            samp_q      <= 2'b11;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= push_req && fifo_full && !pop;

            if (cnt_q == CNT_CM1) samp_q[0] <= rxs_q;
            if (cnt_q == CNT_C)   samp_q[1] <= rxs_q;
            cnt_q <= at_wrap ? '0 : cnt_q + 1'b1;

            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (fall) state_q <= StStart;
                end
                StStart: begin
                    if (at_vote && vote) begin
                        state_q <= StIdle;  // false start
                    end else if (at_wrap) begin
                        state_q   <= StData;
                        bit_idx_q <= '0;
                        perr_q    <= 1'b0;
                    end
                end
                StData: begin
                    if (at_vote) shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
                    if (at_wrap) begin
                        if (bit_idx_q == BIT_LAST) begin
                            stop_idx_q <= 1'b0;
                            if (PARITY != PAR_NONE) state_q <= StParity;
                            else                    state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                StParity: begin
                    if (at_vote) perr_q <= (vote != par_exp);
                    if (at_wrap) state_q <= StStop;
                end
                StStop: begin
                    if (at_vote) begin
                        if (!vote) begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end else if (last_stop) begin
                            // Leave mid stop bit so a back-to-back start edge is caught.
                            state_q <= StIdle;
                        end
                    end else if (at_wrap) begin
                        stop_idx_q <= stop_idx_q + 1'b1;
                    end
                end
                StBreak: begin
                    if (rxs_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sync_fifo_fwft #(
        .WIDTH(DATA_BITS + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push_req),
        .wdata({perr_q, shreg_q}),
        .full (fifo_full),
        .rdata(fifo_rdata),
        .valid(rx_valid),
        .pop  (rx_ready)
    );

    assign rx_data   = fifo_rdata[DATA_BITS-1:0];
    assign rx_perr   = fifo_rdata[DATA_BITS];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: dut_a uses default parameters (8N1), dut_b uses 7 data bits, even parity.
module tb_uart_rx_fifo;

    localparam int CPB   = 106;
    localparam int C     = CPB / 2;
    // Cycles from start-bit drive to first rx_valid sample: 9 bit times + C + 5.
    localparam int LAT   = 9 * CPB + C + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       perr_a, perr_b, valid_a, valid_b, fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;

    uart_rx_fifo dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_perr(perr_a),
        .rx_valid(valid_a), .rx_ready(ready_a), .frame_err(fe_a), .overrun(ov_a),
        .busy(busy_a)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_perr(perr_b),
        .rx_valid(valid_b), .rx_ready(ready_b), .frame_err(fe_b), .overrun(ov_b),
        .busy(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitors sample on the falling edge, away from the active edge.
    logic [8:0] pops_a[$], pops_b[$];
    int         rises_a[$], rises_b[$];
    int         fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_b = 0, ov_cnt_b = 0, dbl = 0;
    logic       vp_a = 0, vp_b = 0, fp_a = 0, fp_b = 0, op_a = 0, op_b = 0;

    always @(negedge clk) begin
        if (valid_a && !vp_a) rises_a.push_back(cyc);
        if (valid_b && !vp_b) rises_b.push_back(cyc);
        if (valid_a && ready_a) pops_a.push_back({perr_a, data_a});
        if (valid_b && ready_b) pops_b.push_back({perr_b, 1'b0, data_b});
        if (fe_a) fe_cnt_a++;
        if (ov_a) ov_cnt_a++;
        if (fe_b) fe_cnt_b++;
        if (ov_b) ov_cnt_b++;
        if ((fe_a && fp_a) || (ov_a && op_a) || (fe_b && fp_b) || (ov_b && op_b)) dbl++;
        vp_a = valid_a; vp_b = valid_b;
        fp_a = fe_a; fp_b = fe_b; op_a = ov_a; op_b = ov_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pop_at(input bit sel, input int i);
        if (sel) return (i < pops_b.size()) ? pops_b[i] : 9'bx;
        return (i < pops_a.size()) ? pops_a[i] : 9'bx;
    endfunction

    function automatic int rise_at(input bit sel, input int i);
        if (sel) return (i < rises_b.size()) ? rises_b[i] : -1;
        return (i < rises_a.size()) ? rises_a[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    // One frame; called 2 time units after a rising edge. t0 marks the start-bit drive.
    task automatic send(input bit sel, input logic [8:0] d, input int nd, input bit has_par,
                        input logic pb, input logic sv, input int ns, input bit spike,
                        output int t0);
        t0 = cyc;
        drive(sel, 1'b0);
        tick(CPB);
        for (int i = 0; i < nd; i++) begin
            drive(sel, d[i]);
            if (spike) begin
                tick(C);
                drive(sel, 1'b1);
                tick(1);
                drive(sel, d[i]);
                tick(CPB - C - 1);
            end else begin
                tick(CPB);
            end
        end
        if (has_par) begin
            drive(sel, pb);
            tick(CPB);
        end
        drive(sel, sv);
        tick(ns * CPB);
        drive(sel, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, ba, bb, ra, rb, fb, ob, g, el;
        bit seen;

        // Reset state
        tick(3);
        check("rst valid", valid_a, 0);
        check("rst data", data_a, 0);
        check("rst perr", perr_a, 0);
        check("rst frame_err", fe_a, 0);
        check("rst overrun", ov_a, 0);
        check("rst busy", busy_a, 0);
        check("rst valid b", valid_b, 0);
        rst_n = 1'b1;
        tick(5);

        // Back-to-back 0x55, 0xA3
        ba = pops_a.size(); ra = rises_a.size();
        send(0, 9'h055, 8, 0, 0, 1, 1, 0, t0);
        send(0, 9'h0A3, 8, 0, 0, 1, 1, 0, t1);
        tick(20);
        check("b2b count", pops_a.size() - ba, 2);
        check("b2b 0x55", pop_at(0, ba), 9'h055);
        check("b2b 0xA3", pop_at(0, ba + 1), 9'h0A3);
        check("b2b lat 1", rise_at(0, ra), t0 + LAT);
        check("b2b lat 2", rise_at(0, ra + 1), t1 + LAT);

        // Stop bit held low for two bit times
        ba = pops_a.size(); fb = fe_cnt_a;
        send(0, 9'h03C, 8, 0, 0, 0, 2, 0, t0);
        check("break busy held", busy_a, 1);
        tick(4);
        check("break busy released", busy_a, 0);
        check("break frame_err", fe_cnt_a - fb, 1);
        check("break no push", pops_a.size() - ba, 0);
        send(0, 9'h001, 8, 0, 0, 1, 1, 0, t0);
        tick(20);
        check("after break 0x01", pop_at(0, ba), 9'h001);

        // 20-cycle glitch on an idle line
        ba = pops_a.size(); fb = fe_cnt_a; ob = ov_cnt_a;
        drive(0, 1'b0);
        g = cyc;
        tick(20);
        drive(0, 1'b1);
        seen = 0; el = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_a) seen = 1;
            else if (seen) begin
                el = cyc - g - 1;
                break;
            end
        end
        check("glitch busy rose", seen, 1);
        check("glitch busy fall bound", (el >= 0) && (el <= C + 4), 1);
        tick(CPB);
        check("glitch no push", pops_a.size() - ba, 0);
        check("glitch no flags", (fe_cnt_a - fb) + (ov_cnt_a - ob), 0);

        // Overrun with the consumer stalled
        ready_a = 1'b0;
        ob = ov_cnt_a;
        for (int i = 0; i < 5; i++) send(0, 9'(8'h10 + i), 8, 0, 0, 1, 1, 0, t0);
        tick(20);
        check("ovr pulse", ov_cnt_a - ob, 1);
        check("ovr valid", valid_a, 1);
        check("ovr head", data_a, 8'h10);
        ba = pops_a.size();
        ready_a = 1'b1;
        tick(10);
        check("ovr drained", pops_a.size() - ba, 4);
        for (int i = 0; i < 4; i++) check("ovr order", pop_at(0, ba + i), 9'(8'h10 + i));
        check("ovr empty", valid_a, 0);

        // Even parity, 7 data bits; third frame carries mid-bit 1-spikes
        bb = pops_b.size(); rb = rises_b.size();
        send(1, 9'h041, 7, 1, 0, 1, 1, 0, t0);
        send(1, 9'h041, 7, 1, 1, 1, 1, 0, t1);
        send(1, 9'h041, 7, 1, 0, 1, 1, 1, t2);
        tick(20);
        check("par count", pops_b.size() - bb, 3);
        check("par good", pop_at(1, bb), 9'h041);
        check("par bad", pop_at(1, bb + 1), 9'h141);
        check("par spike", pop_at(1, bb + 2), 9'h041);
        check("par lat", rise_at(1, rb), t0 + LAT);
        check("par no flags", fe_cnt_b + ov_cnt_b, 0);

        // Reset during data bit 4 with two entries queued
        ready_a = 1'b0;
        fb = fe_cnt_a; ob = ov_cnt_a;
        send(0, 9'h021, 8, 0, 0, 1, 1, 0, t0);
        send(0, 9'h022, 8, 0, 0, 1, 1, 0, t0);
        tick(20);
        check("pre-rst valid", valid_a, 1);
        check("pre-rst head", data_a, 8'h21);
        fork
            send(0, 9'h0F0, 8, 0, 0, 1, 1, 0, t1);
            begin
                tick(5 * CPB + 40);
                rst_n = 1'b0;
                #1;
                check("mid-rst busy", busy_a, 0);
                check("mid-rst valid", valid_a, 0);
                check("mid-rst data", {perr_a, data_a}, 0);
                check("mid-rst pulses", {fe_a, ov_a}, 0);
                tick(3);
                rst_n = 1'b1;
            end
        join
        tick(20);
        check("post-rst valid", valid_a, 0);
        check("post-rst busy", busy_a, 0);
        ba = pops_a.size();
        ready_a = 1'b1;
        tick(5);
        check("post-rst flushed", pops_a.size() - ba, 0);
        send(0, 9'h07E, 8, 0, 0, 1, 1, 0, t0);
        tick(20);
        check("post-rst 0x7E", pop_at(0, ba), 9'h07E);
        check("post-rst no flags", (fe_cnt_a - fb) + (ov_cnt_a - ob), 0);
        check("pulse width", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
